seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles per digit slot, legal range 2..2^20.
REQ-003 Port clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port value  input  4*DIGITS  nibble k is the code for digit k; digit 0 is least significant.
REQ-006 Port load  input  1  when high, value and dp_in SHALL be captured at the next edge.
REQ-007 Port dp_in  input  DIGITS  decimal-point request per digit, active-high.
REQ-008 Port lzb  input  1  leading-zero blanking enable, sampled live.
REQ-009 Port blank  input  1  when high, all digits SHALL be dark, sampled live.
REQ-010 Port seg  output  7  active-low segments a..g in bits 6..0 (0 -> 0000001, 1 -> 1001111, 8 -> 0000000).
REQ-011 Port dp  output  1  decimal point, active-low.
REQ-012 Port an  output  DIGITS  digit enables, active-low, at most one bit low.

Function
REQ-013 The divider SHALL count 0..SCAN_DIV-1 and wrap; tick SHALL assert in the cycle the count equals SCAN_DIV-1.
REQ-014 On tick, the digit index SHALL advance by 1 and wrap from DIGITS-1 to 0.
REQ-015 On load, the value and dp registers SHALL be updated at the next edge; the held data SHALL stay unchanged otherwise.
REQ-016 seg, dp and an SHALL be registered: each reflects the index and held data of the previous cycle (latency 1 clock).
REQ-017 When a load and a tick occur in the same cycle, both SHALL take effect, and the newly selected digit SHALL show the new data one cycle later.
REQ-018 Codes 0-9 SHALL decode to the standard patterns: 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 9=0000100.
REQ-019 Codes 10-15 SHALL decode per REQ-033.
REQ-020 With lzb high, digit k (k>=1) SHALL be blanked when nibble k and all higher nibbles are 0.
REQ-021 Digit 0 SHALL never be blanked by lzb.
REQ-022 A blanked digit SHALL drive seg=1111111 and dp=1; its an bit SHALL still go low so the scan duty stays uniform.
REQ-023 With blank high, the registered outputs SHALL be an=all-ones, seg=1111111 and dp=1.
REQ-024 blank SHALL NOT stop the divider or the index.
REQ-025 an SHALL be one-hot-low at the index bit whenever blank is low.

Reset
REQ-026 While rst is high at an edge, the divider, index, held value and held dp SHALL clear to 0.
REQ-027 While rst is high at an edge, the outputs SHALL be seg=1111111, dp=1 and an=all-ones.
REQ-028 rst SHALL override load, tick and blank.
REQ-029 A reset asserted mid-slot SHALL abort the slot.
REQ-030 The first edge after rst deasserts SHALL begin digit 0 with divider 0.
REQ-031 The first visible output SHALL appear one edge after reset release: an with bit0=0 and seg=0000001.
REQ-032 No outputs SHALL be undefined (X) after the first reset edge.

Configuration
REQ-033 Macro SEG7_HEX_EN controls codes 10-15.
- Defined: 10-15 decode to A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Undefined: 10-15 decode to 1111111 (dark) and the dp bit is unaffected.

Verification (DIGITS=4, SCAN_DIV=4)
REQ-034 Reset release, then run for 16 clocks -> an steps 1110, 1101, 1011, 0111, each held for 4 clocks; seg=0000001 throughout.
REQ-035 load with value=16'h1234 and dp_in=4'b0100 -> the digit-2 slot shows seg=0010010 with dp=0, and the digit-0 slot shows seg=1001100 with dp=1.
REQ-036 value=16'h0070 with lzb=1 -> digits 3 and 2 show 1111111, digit 1 shows 0001111, and digit 0 shows 0000001.
REQ-037 value=16'h00AF -> with SEG7_HEX_EN defined, digit 1 shows 0001000 and digit 0 shows 0111000; with it undefined, both show 1111111.
REQ-038 load coincident with tick at divider=3 -> the next slot shows the new nibble exactly one clock after the index changes.
REQ-039 Pulse rst for one cycle mid-slot at index 2 -> the next cycle gives an=1111; the following cycle gives an=1110; held value reads 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment display driver: time-slices DIGITS digits at SCAN_DIV clocks each.
// Optional macro SEG7_HEX_EN enables A-F glyphs for codes 10-15 (dark when undefined).
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lzb,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_DARK = 7'b1111111;

  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dpr_q, dpr_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick;
  logic [DIGITS-1:0]   lz;
  logic                allz;
  logic [3:0]          nib;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
`ifdef SEG7_HEX_EN
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
`else
      default: s = SEG_DARK;
`endif
    endcase
    return s;
  endfunction

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    val_d = load ? value : val_q;
    dpr_d = load ? dp_in : dpr_q;
  end

  // lz[k]: nibble k and everything above it are zero; digit 0 is always shown
  always_comb begin
    lz   = '0;
    allz = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      allz  = allz & (val_q[4*k +: 4] == 4'h0);
      lz[k] = allz;
    end
    lz[0] = 1'b0;
  end

  always_comb begin
    nib   = val_q[{idx_q, 2'b00} +: 4];
    an_d  = '1;
    seg_d = SEG_DARK;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d[idx_q] = 1'b0;
      if (!(lzb && lz[idx_q])) begin
        seg_d = decode(nib);
        dp_d  = ~dpr_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      val_q <= '0;
      dpr_q <= '0;
      seg_q <= SEG_DARK;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      val_q <= val_d;
      dpr_q <= dpr_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
